// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: one word-addressed request, WAIT wait states, one-cycle ready.
// Optional error reporting on misaligned/out-of-range addresses is enabled with `define DM_RESP_ERR_EN.
module dm_resp #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy
`ifdef DM_RESP_ERR_EN
   ,output logic       err
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'((WAIT == 0) ? 0 : WAIT - 1);

   state_t              state, state_n;
   logic [3:0]          cnt, cnt_n;
   logic                go_resp;

   logic                we_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;

   logic                op_we;
   logic [ADDR_W-1:0]   op_idx;
   logic [31:0]         op_wdata;
   logic [3:0]          op_be;
   logic                op_err;
   logic                mem_wr;

   logic [31:0]         mem [0:(1<<ADDR_W)-1];

   // With WAIT=0 the response is committed on the accept edge, so operands come straight from the inputs.
   assign op_we    = (state == ST_IDLE) ? we : we_q;
   assign op_idx   = (state == ST_IDLE) ? addr[ADDR_W+1:2] : idx_q;
   assign op_wdata = (state == ST_IDLE) ? wdata : wdata_q;
   assign op_be    = (state == ST_IDLE) ? be : be_q;

`ifdef DM_RESP_ERR_EN
   logic err_q;
   logic err_r;
   logic addr_bad;

   assign addr_bad = (addr[1:0] != 2'b00) || (|addr[31:ADDR_W+2]);
   assign op_err   = (state == ST_IDLE) ? addr_bad : err_q;
   assign err      = err_r;
`else
   logic unused_addr;

   assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
   assign op_err      = 1'b0;
`endif

   assign mem_wr = go_resp && op_we && !op_err && rst;
   assign ready  = (state == ST_RESP);
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      go_resp = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (WAIT == 0) begin
                  state_n = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_n = ST_WAIT;
                  cnt_n   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_n = ST_RESP;
               go_resp = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else if (state == ST_IDLE && req) begin
         we_q    <= we;
         idx_q   <= addr[ADDR_W+1:2];
         wdata_q <= wdata;
         be_q    <= be;
      end
   end

`ifdef DM_RESP_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
         err_r <= 1'b0;
      end else begin
         if (state == ST_IDLE && req) err_q <= addr_bad;
         if (go_resp) err_r <= op_err;
      end
   end
`endif

   // Read data is always registered; writes and error responses return zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= 32'd0;
      end else if (go_resp) begin
         rdata <= (op_we || op_err) ? 32'd0 : mem[op_idx];
      end
   end

   // Storage is deliberately not reset; mem_wr is gated by rst so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dm_resp.sv
// Directed self-checking bench for dm_resp (ADDR_W=10, WAIT=2); covers DM_RESP_ERR_EN when defined.
module tb_dm_resp;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err_s;

   int n_checks;
   int n_fails;

   logic [31:0] rd;
   logic        er;
   int          edges;
   logic        rdy_after;

   dm_resp #(.ADDR_W(10), .WAIT(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata),
      .ready (ready),
      .busy  (busy)
`ifdef DM_RESP_ERR_EN
      ,.err  (err_s)
`endif
   );

`ifndef DM_RESP_ERR_EN
   assign err_s = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction; inputs are scrambled after acceptance to prove they were latched.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, output logic [31:0] rd_o, output logic er_o,
                                output int edges_o, output logic rdy_after_o);
      we = w; addr = a; wdata = d; be = b; req = 1'b1;
      edges_o = 0;
      do begin
         @(posedge clk); #1;
         edges_o++;
         if (edges_o == 1) begin
            req = 1'b0; we = ~w; addr = 32'h0000_0FFC; wdata = ~d; be = ~b;
         end
      end while (!ready && edges_o < 20);
      rd_o = rdata;
      er_o = err_s;
      @(posedge clk); #1;
      rdy_after_o = ready;
   endtask

   initial begin
      int k;
      int busy_low;
      logic got_ready;
      logic [31:0] exp_rd [3];
      int bound;

      n_checks = 0;
      n_fails  = 0;
      exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3;

      rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'd0; be = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", {31'd0, ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_accept", {31'd0, busy}, 32'd1);
      req = 1'b0;
      bound = 0;
      while (busy && bound < 10) begin
         @(posedge clk); #1;
         bound++;
      end
      checkOutput("rst_drain", {31'd0, busy}, 32'd0);

      $display("[TB] write/read with WAIT=2");
      applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, edges, rdy_after);
      checkOutput("wr_latency", edges, 32'd3);
      checkOutput("wr_rdata0", rd, 32'd0);
      checkOutput("wr_pulse1", {31'd0, rdy_after}, 32'd0);
      applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("rd_latency", edges, 32'd3);
      checkOutput("rd_data", rd, 32'hDEADBEEF);
      checkOutput("rd_err", {31'd0, er}, 32'd0);

      $display("[TB] byte enables");
      applyStimulus(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, edges, rdy_after);
      checkOutput("be_wr_lat", edges, 32'd3);
      applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("be_merge", rd, 32'hDE22BE44);
      applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, edges, rdy_after);
      checkOutput("be0_resp", edges, 32'd3);
      applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("be0_keep", rd, 32'hDE22BE44);

      $display("[TB] back-to-back reads");
      applyStimulus(1'b1, 32'h0, 32'd1, 4'hF, rd, er, edges, rdy_after);
      applyStimulus(1'b1, 32'h4, 32'd2, 4'hF, rd, er, edges, rdy_after);
      applyStimulus(1'b1, 32'h8, 32'd3, 4'hF, rd, er, edges, rdy_after);
      we = 1'b0; addr = 32'h0; be = 4'h0; req = 1'b1;
      k = 0;
      busy_low = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (i <= 10 && !busy) busy_low++;
         if (ready) begin
            if (k < 3) begin
               checkOutput("b2b_data", rdata, exp_rd[k]);
               checkOutput("b2b_cycle", i, 32'(2 + 4*k));
            end
            k++;
            addr = 32'(4*k);
            if (k >= 3) req = 1'b0;
         end
      end
      checkOutput("b2b_count", k, 32'd3);
      checkOutput("b2b_idle", busy_low, 32'd2);

      $display("[TB] reset during wait");
      applyStimulus(1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, edges, rdy_after);
      we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      checkOutput("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_ready", {31'd0, ready}, 32'd0);
      #2 rst = 1'b1;
      got_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ready) got_ready = 1'b1;
      end
      checkOutput("mid_no_ready", {31'd0, got_ready}, 32'd0);
      applyStimulus(1'b0, 32'h20, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("mid_prior", rd, 32'h12345678);

`ifdef DM_RESP_ERR_EN
      $display("[TB] error responses");
      applyStimulus(1'b0, 32'h00001000, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("err_hi_lat", edges, 32'd3);
      checkOutput("err_hi_flag", {31'd0, er}, 32'd1);
      checkOutput("err_hi_rdata", rd, 32'd0);
      applyStimulus(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, rd, er, edges, rdy_after);
      checkOutput("err_mis_flag", {31'd0, er}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("err_mem_keep", rd, 32'd1);
      checkOutput("err_legal", {31'd0, er}, 32'd0);
`else
      $display("[TB] address aliasing");
      applyStimulus(1'b0, 32'h00001000, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("alias_hi", rd, 32'd1);
      applyStimulus(1'b0, 32'h12, 32'd0, 4'h0, rd, er, edges, rdy_after);
      checkOutput("alias_lo", rd, 32'hDE22BE44);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
